// File: rtl/dmi_wb_pkg.sv
// dmi_wb_pkg: DMI op/response codes and master FSM state encodings
package dmi_wb_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RSV = 2'd3} dmi_op_e;
  typedef enum logic [1:0] {RSP_SUCCESS = 2'd0, RSP_FAILED = 2'd2} dmi_rsp_e;
  typedef enum logic [1:0] {IDLE, BUS, RELEASE, RESP} state_e;
endpackage

// File: rtl/dmi_wb_timeout.sv
// dmi_wb_timeout: bus-cycle counter, expired during the LIMIT-th enabled cycle
module dmi_wb_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT - 1);
  always_ff @(posedge clk_i) begin
    if (!rst_i || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/dmi_wishbone_master.sv
// dmi_wishbone_master: turns DMI requests into single Wishbone cycles with timeout
module dmi_wishbone_master
  import dmi_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_op_o,
  output logic [31:0]       rsp_data_o,
  output logic [31:0]       wb_addr_o,
  output logic [63:0]       wb_data_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic [63:0]       wb_data_i,
  input  logic              wb_ack_i,
  output logic              busy_o
);
  state_e state, state_n;
  logic armed, accept, expired, unused_hi;
  logic [1:0] op, rsp_op, rsp_op_n;
  logic [ADDR_W-1:0] addr;
  logic [31:0] data, rsp_data, rsp_data_n;
  // armed keeps req_ready low while reset is held, even though state is IDLE
  assign req_ready_o = armed && state == IDLE;
  assign accept = req_valid_i && req_ready_o;
  assign wb_cyc_o = state == BUS;
  assign wb_stb_o = state == BUS;
  assign wb_we_o = state == BUS && op == OP_WRITE;
  assign wb_addr_o = state == BUS ? 32'(addr) : '0;
  assign wb_data_o = wb_we_o ? {32'b0, data} : '0;
  assign rsp_valid_o = state == RESP;
  assign rsp_op_o = rsp_op;
  assign rsp_data_o = rsp_data;
  assign busy_o = state != IDLE;
  assign unused_hi = ^wb_data_i[63:32];
  dmi_wb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr(state != BUS),
    .en(state == BUS),
    .expired(expired)
  );
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      armed <= 1'b0;
      op <= OP_NOP;
      addr <= '0;
      data <= '0;
      rsp_op <= RSP_SUCCESS;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      armed <= 1'b1;
      rsp_op <= rsp_op_n;
      rsp_data <= rsp_data_n;
      if (accept) begin
        op <= req_op_i;
        addr <= req_addr_i;
        data <= req_data_i;
      end
    end
  end
  always_comb begin
    state_n = state;
    rsp_op_n = rsp_op;
    rsp_data_n = rsp_data;
    case (state)
      IDLE: if (accept) begin
        state_n = (req_op_i == OP_READ || req_op_i == OP_WRITE) ? BUS : RESP;
        rsp_op_n = req_op_i == OP_RSV ? RSP_FAILED : RSP_SUCCESS;
        rsp_data_n = '0;
      end
      BUS: if (wb_ack_i) begin
        state_n = RELEASE;
        rsp_op_n = RSP_SUCCESS;
        rsp_data_n = op == OP_READ ? wb_data_i[31:0] : '0;
      end else if (expired) begin
        state_n = RELEASE;
        rsp_op_n = RSP_FAILED;
        rsp_data_n = '0;
      end
      RELEASE: state_n = wb_ack_i ? RELEASE : RESP;
      RESP: state_n = rsp_ready_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmi_wishbone_master.sv
// tb_dmi_wishbone_master: directed and random DMI transactions against an outcome model
module tb_dmi_wishbone_master;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, rsp_valid, rsp_ready, wb_we, wb_cyc, wb_stb, wb_ack, busy;
  logic [1:0] req_op, rsp_op;
  logic [6:0] req_addr;
  logic [31:0] req_data, rsp_data, wb_addr;
  logic [63:0] wb_wdata, wb_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmi_wishbone_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(7)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op), .rsp_data_o(rsp_data),
    .wb_addr_o(wb_addr), .wb_data_o(wb_wdata), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc),
    .wb_stb_o(wb_stb), .wb_data_i(wb_rdata), .wb_ack_i(wb_ack), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // One DMI transaction: slave acks in cyc cycle 'delay' (0-based), holds ack 'drop' extra cycles after cyc falls
  task automatic run(input string tag, input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                     input int delay, input logic [63:0] rdata, input int hold, input int drop);
    int guard, cyc_n, rdy_seen, viol, left, e_cyc;
    logic bus, ok, stable, w, s;
    logic [31:0] a, e_data;
    logic [63:0] d;
    logic [1:0] e_op;
    bus = op == 2'd1 || op == 2'd2;
    ok = !bus || delay < TO;
    e_op = (op == 2'd3 || !ok) ? 2'd2 : 2'd0;
    e_data = (op == 2'd1 && ok) ? rdata[31:0] : 32'h0;
    e_cyc = !bus ? 0 : (ok ? delay + 1 : TO);
    a = '0; d = '0; w = 1'b0; s = 1'b0;
    cyc_n = 0; viol = 0; rdy_seen = 0; left = drop; stable = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    chk({tag, ":accept"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = 7'($urandom); req_data = $urandom;
    guard = 0;
    while (!rsp_valid && guard < 60) begin
      if (wb_cyc) begin
        if (cyc_n == 0) begin a = wb_addr; d = wb_wdata; w = wb_we; s = wb_stb; end
        if (cyc_n == delay) begin wb_ack = 1'b1; wb_rdata = rdata; end
        cyc_n++;
      end else if (wb_ack) begin
        if (wb_stb || wb_we || wb_addr != 0 || wb_wdata != 0) viol++;
        if (left == 0) wb_ack = 1'b0; else left--;
      end
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
      if (rsp_valid && wb_ack) viol++;
    end
    rsp_ready = 1'b0;
    chk({tag, ":rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, ":rsp_op"}, 64'(rsp_op), 64'(e_op));
    chk({tag, ":rsp_data"}, 64'(rsp_data), 64'(e_data));
    chk({tag, ":cyc_cycles"}, 64'(cyc_n), 64'(e_cyc));
    chk({tag, ":wb_addr"}, 64'(a), bus ? 64'(addr) : 64'd0);
    chk({tag, ":wb_wdata"}, d, op == 2'd2 ? {32'h0, data} : 64'd0);
    chk({tag, ":wb_we"}, 64'(w), 64'(op == 2'd2));
    chk({tag, ":wb_stb"}, 64'(s), 64'(bus));
    chk({tag, ":ack_overlap"}, 64'(viol), 64'd0);
    chk({tag, ":busy"}, 64'(busy), 64'd1);
    req_valid = 1'b1; req_op = 2'd1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_op !== e_op || rsp_data !== e_data) stable = 1'b0;
      if (req_ready) rdy_seen++;
    end
    chk({tag, ":rsp_stable"}, 64'(stable), 64'd1);
    chk({tag, ":ready_in_resp"}, 64'(rdy_seen), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk({tag, ":rsp_done"}, 64'(rsp_valid), 64'd0);
    chk({tag, ":idle_ready"}, 64'(req_ready), 64'd1);
    chk({tag, ":idle_busy"}, 64'(busy), 64'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g;
    rst = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset:outs", {wb_addr, 2'(wb_cyc + wb_stb + wb_we), rsp_op, 1'b0, rsp_valid, req_ready, busy, 24'h0},
        64'd0);
    chk("reset:wdata", wb_wdata, 64'd0);
    chk("reset:rsp_data", 64'(rsp_data), 64'd0);
    chk("reset:ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset:ready", 64'(req_ready), 64'd1);
    run("write10", 2'd2, 7'h10, 32'h8000_0000, 2, 64'h0, 0, 1);
    run("read04", 2'd1, 7'h04, 32'h0, 0, 64'hDEAD_BEEF_1234_5678, 0, 0);
    run("timeout", 2'd1, 7'h22, 32'h0, 1000, 64'h1, 1, 0);
    run("nop", 2'd0, 7'h05, 32'h1234, 0, 64'h0, 0, 0);
    run("op3", 2'd3, 7'h05, 32'h1234, 0, 64'h0, 0, 0);
    run("hold10", 2'd1, 7'h7F, 32'h0, 3, 64'hFFFF_FFFF_CAFE_F00D, 10, 2);
    run("ack_last", 2'd2, 7'h01, 32'hA5A5_5A5A, TO - 1, 64'h0, 1, 3);
    run("ack_late", 2'd1, 7'h02, 32'h0, TO, 64'h0000_0000_1111_2222, 0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h33; req_data = '0;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_bus:cyc1", 64'(wb_cyc), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_bus:cyc", 64'(wb_cyc), 64'd0);
    chk("rst_bus:stb", 64'(wb_stb), 64'd0);
    chk("rst_bus:rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_bus:busy", 64'(busy), 64'd0);
    chk("rst_bus:ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_bus:ready_after", 64'(req_ready), 64'd1);
    run("read_after_rst", 2'd1, 7'h11, 32'h0, 1, 64'h0BAD_0BAD_7654_3210, 0, 1);
    for (int i = 0; i < 40; i++)
      run($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 7'($urandom), $urandom,
          int'($urandom_range(0, TO + 2)), {$urandom, $urandom}, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
